// File: rtl/ucontrol_sequencer_if.sv
// ucontrol_sequencer_if: bus bundle between the microprogrammed control unit and
// its surroundings (control store ROM, instruction register, ALU flags, memory
// handshake and the datapath's MIR-side inputs).
//
// Modports:
//   master - the sequencer: drives the control store address, datapath controls and PSR;
//            samples microword, IR, SetCode, active-low ALU flags and MemReady.
//   slave  - the environment: the mirror image of master.
interface ucontrol_sequencer_if #(
   parameter int unsigned DATAWIDTH_BUS           = 32,
   parameter int unsigned DATAWIDTH_MIR_DIRECTION = 6,
   parameter int unsigned DATAWIDTH_ALU_SELECTION = 4,
   parameter int unsigned DATAWIDTH_CSAR          = 11,
   parameter int unsigned DATAWIDTH_MICROWORD     = 41
);
   logic [DATAWIDTH_CSAR-1:0]          uCONTROL_CSAddress_OutBus;
   logic [DATAWIDTH_MICROWORD-1:0]     uCONTROL_CSData_InBus;
   logic [DATAWIDTH_BUS-1:0]           uCONTROL_IR_InBus;
   logic                               uCONTROL_SetCode_In;
   logic                               uCONTROL_FlagNegative_In;
   logic                               uCONTROL_FlagZero_In;
   logic                               uCONTROL_FlagOverflow_In;
   logic                               uCONTROL_FlagCarry_In;
   logic                               uCONTROL_MemReady_In;
   logic [DATAWIDTH_MIR_DIRECTION-1:0] uCONTROL_DirA_OutBus;
   logic [DATAWIDTH_MIR_DIRECTION-1:0] uCONTROL_DirB_OutBus;
   logic [DATAWIDTH_MIR_DIRECTION-1:0] uCONTROL_DirC_OutBus;
   logic                               uCONTROL_SelectA_Out;
   logic                               uCONTROL_SelectB_Out;
   logic                               uCONTROL_SelectC_Out;
   logic                               uCONTROL_RD_Out;
   logic                               uCONTROL_WR_Out;
   logic [DATAWIDTH_ALU_SELECTION-1:0] uCONTROL_ALUOperation_OutBus;
   logic [3:0]                         uCONTROL_PSR_OutBus;

   modport master (
      output uCONTROL_CSAddress_OutBus,
      input  uCONTROL_CSData_InBus,
      input  uCONTROL_IR_InBus,
      input  uCONTROL_SetCode_In,
      input  uCONTROL_FlagNegative_In,
      input  uCONTROL_FlagZero_In,
      input  uCONTROL_FlagOverflow_In,
      input  uCONTROL_FlagCarry_In,
      input  uCONTROL_MemReady_In,
      output uCONTROL_DirA_OutBus,
      output uCONTROL_DirB_OutBus,
      output uCONTROL_DirC_OutBus,
      output uCONTROL_SelectA_Out,
      output uCONTROL_SelectB_Out,
      output uCONTROL_SelectC_Out,
      output uCONTROL_RD_Out,
      output uCONTROL_WR_Out,
      output uCONTROL_ALUOperation_OutBus,
      output uCONTROL_PSR_OutBus
   );

   modport slave (
      input  uCONTROL_CSAddress_OutBus,
      output uCONTROL_CSData_InBus,
      output uCONTROL_IR_InBus,
      output uCONTROL_SetCode_In,
      output uCONTROL_FlagNegative_In,
      output uCONTROL_FlagZero_In,
      output uCONTROL_FlagOverflow_In,
      output uCONTROL_FlagCarry_In,
      output uCONTROL_MemReady_In,
      input  uCONTROL_DirA_OutBus,
      input  uCONTROL_DirB_OutBus,
      input  uCONTROL_DirC_OutBus,
      input  uCONTROL_SelectA_Out,
      input  uCONTROL_SelectB_Out,
      input  uCONTROL_SelectC_Out,
      input  uCONTROL_RD_Out,
      input  uCONTROL_WR_Out,
      input  uCONTROL_ALUOperation_OutBus,
      input  uCONTROL_PSR_OutBus
   );
endinterface

// File: rtl/ucontrol_sequencer.sv
// ucontrol_sequencer: microprogrammed control unit for the ARC datapath.
// Holds CSAR, MIR and PSR; sequences FETCH -> EXEC (-> WAIT)* -> FETCH and computes
// the next microaddress (sequential, conditional jump or opcode decode).
//
// Ports:
//   uCONTROL_CLOCK_50        clock
//   uCONTROL_ResetInLow_In   asynchronous active-low reset
//   uCONTROL_Step_In         single-step pulse (only with UCONTROL_SINGLESTEP_EN)
//   bus                      ucontrol_sequencer_if.master (control store, IR, flags,
//                            memory handshake, datapath controls, PSR)
//
// Optional feature: define UCONTROL_SINGLESTEP_EN to hold FETCH until a registered
// rising edge of uCONTROL_Step_In; one microinstruction executes per pulse.
module ucontrol_sequencer #(
   parameter int unsigned DATAWIDTH_BUS           = 32,
   parameter int unsigned DATAWIDTH_MIR_DIRECTION = 6,
   parameter int unsigned DATAWIDTH_ALU_SELECTION = 4,
   parameter int unsigned DATAWIDTH_CSAR          = 11,
   parameter int unsigned DATAWIDTH_MICROWORD     = 41,
   parameter logic [DATAWIDTH_CSAR-1:0] CSAR_RESET = '0
) (
   input logic                  uCONTROL_CLOCK_50,
   input logic                  uCONTROL_ResetInLow_In,
`ifdef UCONTROL_SINGLESTEP_EN
   input logic                  uCONTROL_Step_In,
`endif
   ucontrol_sequencer_if.master bus
);

   // Microword field positions, LSB upwards: JADDR, COND, ALU, WR, RD, CMUX, C, BMUX, B, AMUX, A.
   localparam int unsigned CondLsb = DATAWIDTH_CSAR;
   localparam int unsigned AluLsb  = CondLsb + 3;
   localparam int unsigned WrBit   = AluLsb + DATAWIDTH_ALU_SELECTION;
   localparam int unsigned RdBit   = WrBit + 1;
   localparam int unsigned CmuxBit = RdBit + 1;
   localparam int unsigned CLsb    = CmuxBit + 1;
   localparam int unsigned BmuxBit = CLsb + DATAWIDTH_MIR_DIRECTION;
   localparam int unsigned BLsb    = BmuxBit + 1;
   localparam int unsigned AmuxBit = BLsb + DATAWIDTH_MIR_DIRECTION;
   localparam int unsigned ALsb    = AmuxBit + 1;

   typedef enum logic [1:0] {StFetch, StExec, StWait} state_e;

   state_e                         state_q, state_d;
   logic [DATAWIDTH_CSAR-1:0]      csar_q, csar_d;
   logic [DATAWIDTH_MICROWORD-1:0] mir_q, mir_d;
   logic [3:0]                     psr_q, psr_d;

   logic [DATAWIDTH_MIR_DIRECTION-1:0] mir_a, mir_b, mir_c;
   logic                               mir_amux, mir_bmux, mir_cmux, mir_rd, mir_wr;
   logic [DATAWIDTH_ALU_SELECTION-1:0] mir_alu;
   logic [2:0]                         mir_cond;
   logic [DATAWIDTH_CSAR-1:0]          mir_jaddr;
   logic                               mem_busy;
   logic                               fetch_go;
   logic [DATAWIDTH_CSAR-1:0]          csar_inc, decode_addr, next_csar;
   logic                               unused_ir;

   assign mir_a     = mir_q[ALsb +: DATAWIDTH_MIR_DIRECTION];
   assign mir_amux  = mir_q[AmuxBit];
   assign mir_b     = mir_q[BLsb +: DATAWIDTH_MIR_DIRECTION];
   assign mir_bmux  = mir_q[BmuxBit];
   assign mir_c     = mir_q[CLsb +: DATAWIDTH_MIR_DIRECTION];
   assign mir_cmux  = mir_q[CmuxBit];
   assign mir_rd    = mir_q[RdBit];
   assign mir_wr    = mir_q[WrBit];
   assign mir_alu   = mir_q[AluLsb +: DATAWIDTH_ALU_SELECTION];
   assign mir_cond  = mir_q[CondLsb +: 3];
   assign mir_jaddr = mir_q[DATAWIDTH_CSAR-1:0];

   // RD and WR together still count as a single access waiting on one MemReady.
   assign mem_busy = (mir_rd | mir_wr) & ~bus.uCONTROL_MemReady_In;

   assign unused_ir = ^{bus.uCONTROL_IR_InBus[29:25], bus.uCONTROL_IR_InBus[18:14],
                        bus.uCONTROL_IR_InBus[12:0]};

`ifdef UCONTROL_SINGLESTEP_EN
   logic step_q1, step_q2, step_rise, step_pending_q, step_pending_d;

   assign step_rise = step_q1 & ~step_q2;
   // A pulse seen outside FETCH is remembered so it still releases the next fetch.
   assign fetch_go       = step_pending_q | step_rise;
   assign step_pending_d = (state_q == StFetch) ? 1'b0 : (step_pending_q | step_rise);

   always_ff @(posedge uCONTROL_CLOCK_50 or negedge uCONTROL_ResetInLow_In) begin
      if (!uCONTROL_ResetInLow_In) begin
         step_q1        <= 1'b0;
         step_q2        <= 1'b0;
         step_pending_q <= 1'b0;
      end else begin
         step_q1        <= uCONTROL_Step_In;
         step_q2        <= step_q1;
         step_pending_q <= step_pending_d;
      end
   end
`else
   assign fetch_go = 1'b1;
`endif

   // Next microaddress; branch tests use the PSR as it stood before this cycle.
   always_comb begin
      csar_inc    = csar_q + 1'b1;
      decode_addr = {1'b1, bus.uCONTROL_IR_InBus[31:30], bus.uCONTROL_IR_InBus[24:19], 2'b00};
      next_csar   = csar_inc;
      unique case (mir_cond)
         3'd0: next_csar = csar_inc;
         3'd1: next_csar = psr_q[3] ? mir_jaddr : csar_inc;
         3'd2: next_csar = psr_q[2] ? mir_jaddr : csar_inc;
         3'd3: next_csar = psr_q[1] ? mir_jaddr : csar_inc;
         3'd4: next_csar = psr_q[0] ? mir_jaddr : csar_inc;
         3'd5: next_csar = bus.uCONTROL_IR_InBus[13] ? mir_jaddr : csar_inc;
         3'd6: next_csar = mir_jaddr;
         3'd7: next_csar = decode_addr;
         default: next_csar = csar_inc;
      endcase
   end

   always_comb begin
      state_d = state_q;
      csar_d  = csar_q;
      mir_d   = mir_q;
      psr_d   = psr_q;

      bus.uCONTROL_CSAddress_OutBus    = csar_q;
      bus.uCONTROL_PSR_OutBus          = psr_q;
      bus.uCONTROL_DirA_OutBus         = '0;
      bus.uCONTROL_DirB_OutBus         = '0;
      bus.uCONTROL_DirC_OutBus         = '0;
      bus.uCONTROL_SelectA_Out         = 1'b0;
      bus.uCONTROL_SelectB_Out         = 1'b0;
      bus.uCONTROL_SelectC_Out         = 1'b0;
      bus.uCONTROL_RD_Out              = 1'b0;
      bus.uCONTROL_WR_Out              = 1'b0;
      bus.uCONTROL_ALUOperation_OutBus = '0;

      unique case (state_q)
         StFetch: begin
            if (fetch_go) begin
               mir_d   = bus.uCONTROL_CSData_InBus;
               state_d = StExec;
            end
         end
         // EXEC and WAIT share one rule: while the access is outstanding the C write is
         // suppressed and we sit in WAIT; otherwise this is the terminal cycle.
         StExec, StWait: begin
            bus.uCONTROL_DirA_OutBus         = mir_a;
            bus.uCONTROL_SelectA_Out         = mir_amux;
            bus.uCONTROL_DirB_OutBus         = mir_b;
            bus.uCONTROL_SelectB_Out         = mir_bmux;
            bus.uCONTROL_RD_Out              = mir_rd;
            bus.uCONTROL_WR_Out              = mir_wr;
            bus.uCONTROL_ALUOperation_OutBus = mir_alu;
            if (mem_busy) begin
               state_d = StWait;
            end else begin
               bus.uCONTROL_DirC_OutBus = mir_c;
               bus.uCONTROL_SelectC_Out = mir_cmux;
               csar_d                   = next_csar;
               if (bus.uCONTROL_SetCode_In) begin
                  psr_d = ~{bus.uCONTROL_FlagNegative_In, bus.uCONTROL_FlagZero_In,
                            bus.uCONTROL_FlagOverflow_In, bus.uCONTROL_FlagCarry_In};
               end
               state_d = StFetch;
            end
         end
         default: state_d = StFetch;
      endcase
   end

   always_ff @(posedge uCONTROL_CLOCK_50 or negedge uCONTROL_ResetInLow_In) begin
      if (!uCONTROL_ResetInLow_In) begin
         state_q <= StFetch;
         csar_q  <= CSAR_RESET;
         mir_q   <= '0;
         psr_q   <= '0;
      end else begin
         state_q <= state_d;
         csar_q  <= csar_d;
         mir_q   <= mir_d;
         psr_q   <= psr_d;
      end
   end

endmodule

// File: tb/tb_ucontrol_sequencer.sv
// Self-checking bench for ucontrol_sequencer: directed walk through reset release,
// memory wait, zero branch, wrap, decode and async reset, then randomized microcode
// checked against a per-microinstruction reference model.
module tb_ucontrol_sequencer;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
`ifdef UCONTROL_SINGLESTEP_EN
   logic step  = 1'b0;
`endif

   always #5 clk = ~clk;

   ucontrol_sequencer_if bus ();

   ucontrol_sequencer dut (
      .uCONTROL_CLOCK_50      (clk),
      .uCONTROL_ResetInLow_In (rst_n),
`ifdef UCONTROL_SINGLESTEP_EN
      .uCONTROL_Step_In       (step),
`endif
      .bus                    (bus)
   );

   logic [40:0] rom [2048];
   assign bus.uCONTROL_CSData_InBus = rom[bus.uCONTROL_CSAddress_OutBus];

   int         n_cmp  = 0;
   int         n_fail = 0;
   int         m_csar = 0;
   logic [3:0] m_psr  = 4'b0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [40:0] mk(input logic [5:0] a, input logic amux, input logic [5:0] b,
                                      input logic bmux, input logic [5:0] c, input logic cmux,
                                      input logic rd, input logic wr, input logic [3:0] alu,
                                      input logic [2:0] cond, input logic [10:0] jaddr);
      return {a, amux, b, bmux, c, cmux, rd, wr, alu, cond, jaddr};
   endfunction

   function automatic logic [26:0] dp_obs();
      return {bus.uCONTROL_DirA_OutBus, bus.uCONTROL_SelectA_Out, bus.uCONTROL_DirB_OutBus,
              bus.uCONTROL_SelectB_Out, bus.uCONTROL_DirC_OutBus, bus.uCONTROL_SelectC_Out,
              bus.uCONTROL_RD_Out, bus.uCONTROL_WR_Out, bus.uCONTROL_ALUOperation_OutBus};
   endfunction

   task automatic set_flags(input logic [3:0] fl_n);
      {bus.uCONTROL_FlagNegative_In, bus.uCONTROL_FlagZero_In,
       bus.uCONTROL_FlagOverflow_In, bus.uCONTROL_FlagCarry_In} = fl_n;
   endtask

   // Entered and left at posedge+3 of a FETCH cycle. One microinstruction: fetch, then
   // EXEC plus `waits` extra cycles if it accesses memory.
   task automatic run_uinstr(input int waits, input logic sc, input logic [3:0] fl_n,
                             input logic [31:0] ir);
      logic [40:0] w;
      logic        acc, term, taken;
      int          nw, inc, nxt;
      bus.uCONTROL_IR_InBus = ir;
      #1;
      check("fetch_addr", 64'(bus.uCONTROL_CSAddress_OutBus), 64'(m_csar));
      check("fetch_dp_idle", 64'(dp_obs()), 64'd0);
      check("fetch_psr", 64'(bus.uCONTROL_PSR_OutBus), 64'(m_psr));
      w = rom[m_csar];
      @(posedge clk); #3;
      acc = w[19] | w[18];
      nw  = acc ? waits : 0;
      for (int k = 0; k <= nw; k++) begin
         term = (k == nw);
         bus.uCONTROL_MemReady_In = acc ? term : 1'($urandom_range(0, 1));
         bus.uCONTROL_SetCode_In  = term ? sc : 1'($urandom_range(0, 1));
         set_flags(term ? fl_n : 4'($urandom_range(0, 15)));
         #1;
         // C destination is only visible on the cycle that completes the microinstruction.
         check("exec_dp", 64'(dp_obs()), 64'({w[40:27], (term ? w[26:20] : 7'd0), w[19:14]}));
         check("exec_addr_held", 64'(bus.uCONTROL_CSAddress_OutBus), 64'(m_csar));
         check("exec_psr_held", 64'(bus.uCONTROL_PSR_OutBus), 64'(m_psr));
         if (term) begin
            inc = (m_csar + 1) % 2048;
            case (int'(w[13:11]))
               0:       taken = 1'b0;
               1:       taken = m_psr[3];
               2:       taken = m_psr[2];
               3:       taken = m_psr[1];
               4:       taken = m_psr[0];
               5:       taken = ir[13];
               default: taken = 1'b1;
            endcase
            if (int'(w[13:11]) == 7) nxt = 1024 + int'(ir[31:30]) * 256 + int'(ir[24:19]) * 4;
            else nxt = taken ? int'(w[10:0]) : inc;
            m_csar = nxt;
            if (sc) m_psr = ~fl_n;
         end
         @(posedge clk); #3;
      end
   endtask

   initial begin
      bus.uCONTROL_IR_InBus    = '0;
      bus.uCONTROL_SetCode_In  = 1'b0;
      bus.uCONTROL_MemReady_In = 1'b0;
      set_flags(4'b1111);
      for (int i = 0; i < 2048; i++) rom[i] = '0;
      rom[0]      = mk(6'd0, 0, 6'd0, 0, 6'd5, 0, 0, 0, 4'h3, 3'd0, 11'd0);
      rom[1]      = mk(6'd1, 1, 6'd2, 1, 6'd0, 0, 0, 0, 4'h1, 3'd6, 11'd10);
      rom[10]     = mk(6'd4, 0, 6'd6, 0, 6'd9, 1, 0, 0, 4'h5, 3'd0, 11'd0);
      rom[11]     = mk(6'd0, 0, 6'd0, 0, 6'd0, 0, 0, 0, 4'h0, 3'd2, 11'h400);
      rom[11'h400] = mk(6'd7, 0, 6'd8, 1, 6'd3, 0, 1, 0, 4'h2, 3'd6, 11'h7FF);
      rom[11'h7FF] = mk(6'd0, 0, 6'd0, 0, 6'd1, 0, 0, 0, 4'h0, 3'd0, 11'd0);
      rom[12]     = mk(6'd0, 0, 6'd0, 0, 6'd0, 0, 0, 0, 4'h0, 3'd7, 11'd0);
      rom[11'h600] = mk(6'h2A, 1, 6'd3, 0, 6'd7, 1, 0, 1, 4'h9, 3'd0, 11'd0);

      repeat (3) @(posedge clk);
      #3;
      check("reset_addr", 64'(bus.uCONTROL_CSAddress_OutBus), 64'd0);
      check("reset_dp", 64'(dp_obs()), 64'd0);
      check("reset_psr", 64'(bus.uCONTROL_PSR_OutBus), 64'd0);
      rst_n = 1'b1;

      run_uinstr(0, 1'b0, 4'b1111, 32'd0);                // addr 0: C=5 ALU=3
      check("reset_release_third_addr", 64'(bus.uCONTROL_CSAddress_OutBus), 64'd1);
      run_uinstr(0, 1'b0, 4'b1111, 32'd0);                // addr 1: jump 10
      run_uinstr(0, 1'b1, 4'b1011, 32'd0);                // addr 10: set z
      check("psr_zero_set", 64'(bus.uCONTROL_PSR_OutBus), 64'b0100);
      run_uinstr(0, 1'b0, 4'b1111, 32'd0);                // addr 11: branch on z
      check("zero_branch_taken", 64'(bus.uCONTROL_CSAddress_OutBus), 64'h400);
      run_uinstr(3, 1'b1, 4'b1111, 32'd0);                // RD with three wait cycles
      run_uinstr(0, 1'b0, 4'b1111, 32'd0);                // addr 2047 sequential
      check("csar_wrap", 64'(bus.uCONTROL_CSAddress_OutBus), 64'd0);
      run_uinstr(0, 1'b0, 4'b1111, 32'd0);
      run_uinstr(0, 1'b0, 4'b1111, 32'd0);
      run_uinstr(0, 1'b1, 4'b1111, 32'd0);                // addr 10: z cleared
      run_uinstr(0, 1'b0, 4'b1111, 32'd0);
      check("zero_branch_not_taken", 64'(bus.uCONTROL_CSAddress_OutBus), 64'd12);
      run_uinstr(0, 1'b1, 4'b0000, 32'h8200_4000);        // decode, PSR -> 1111
      check("decode_target", 64'(bus.uCONTROL_CSAddress_OutBus), 64'h600);

      // WR stuck waiting, then reset asserted between clock edges.
      @(posedge clk); #3;
      bus.uCONTROL_MemReady_In = 1'b0;
      #1;
      check("wr_exec", 64'(bus.uCONTROL_WR_Out), 64'd1);
      check("dirc_exec_busy", 64'(bus.uCONTROL_DirC_OutBus), 64'd0);
      @(posedge clk); #3;
      #1;
      check("wr_wait", 64'(bus.uCONTROL_WR_Out), 64'd1);
      check("psr_before_reset", 64'(bus.uCONTROL_PSR_OutBus), 64'hF);
      rst_n = 1'b0;
      #1;
      check("areset_wr", 64'(bus.uCONTROL_WR_Out), 64'd0);
      check("areset_dp", 64'(dp_obs()), 64'd0);
      check("areset_addr", 64'(bus.uCONTROL_CSAddress_OutBus), 64'd0);
      check("areset_psr", 64'(bus.uCONTROL_PSR_OutBus), 64'd0);
      @(posedge clk); @(posedge clk); #3;
      rst_n  = 1'b1;
      m_csar = 0;
      m_psr  = 4'b0;

      for (int i = 0; i < 2048; i++) rom[i] = 41'({$urandom, $urandom});
      for (int n = 0; n < 300; n++) begin
         run_uinstr(int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                    4'($urandom_range(0, 15)), $urandom);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/ucontrol_sequencer.md
Name: ucontrol_sequencer

Overview:
- Microprogrammed control unit for the ARC datapath. It drives the datapath's MIR-side inputs (A/B/C addresses, mux selects, RD, ALU operation) and consumes its condition flags.
- Holds the CSAR, MIR and PSR registers. Computes the next microaddress (sequential, conditional jump, or opcode decode) and stalls on a main-memory handshake for RD/WR microinstructions.

Parameters:
- DATAWIDTH_BUS, 32, data/IR width
- DATAWIDTH_MIR_DIRECTION, 6, A/B/C register address field width
- DATAWIDTH_ALU_SELECTION, 4, ALU operation field width
- DATAWIDTH_CSAR, 11, control store address width
- DATAWIDTH_MICROWORD, 41, microword width
- CSAR_RESET, 11'd0, microaddress entered after reset

Ports:
- uCONTROL_CLOCK_50  in  1  clock
- uCONTROL_ResetInLow_In  in  1  asynchronous active-low reset
- uCONTROL_CSAddress_OutBus  out  11  control store address (combinational ROM outside block)
- uCONTROL_CSData_InBus  in  41  microword from control store
- uCONTROL_IR_InBus  in  32  instruction register contents
- uCONTROL_SetCode_In  in  1  PSR update request from ALU
- uCONTROL_FlagNegative_In / FlagZero_In / FlagOverflow_In / FlagCarry_In  in  1 each  ALU flags, active-low
- uCONTROL_MemReady_In  in  1  main memory transfer complete
- uCONTROL_DirA_OutBus / DirB_OutBus / DirC_OutBus  out  6 each  register addresses to datapath
- uCONTROL_SelectA_Out / SelectB_Out / SelectC_Out  out  1 each  AMUX/BMUX/CMUX selects
- uCONTROL_RD_Out  out  1  memory read / C-bus source select
- uCONTROL_WR_Out  out  1  memory write request
- uCONTROL_ALUOperation_OutBus  out  4  ALU operation
- uCONTROL_PSR_OutBus  out  4  {n,z,v,c} active-high

Behaviour:
- Microword, MSB to LSB: A[40:35] AMUX[34] B[33:28] BMUX[27] C[26:21] CMUX[20] RD[19] WR[18] ALU[17:14] COND[13:11] JADDR[10:0].
- Reset (async, ResetInLow=0): CSAR=CSAR_RESET, MIR=0, PSR=0, state=FETCH. All outputs are 0 during reset. Reset mid-stall aborts the access immediately, and RD/WR drop asynchronously.
- FSM FETCH:
  - CSAddress=CSAR.
  - MIR<=CSData at the clock edge.
  - Datapath outputs are all 0, so C=%r0 and nothing is written.
  - Next state: EXEC.
- FSM EXEC (MIR fields drive the outputs):
  - If RD|WR and MemReady=0: go to WAIT.
  - Otherwise the cycle is terminal: update CSAR and PSR, then go to FETCH.
- FSM WAIT:
  - Hold A, B, AMUX, BMUX, ALU, RD and WR.
  - Force DirC=0 and SelectC=0 (no register write).
  - When MemReady=1: restore the C fields for that cycle; the cycle is terminal; go to FETCH.
- A microinstruction takes 2 cycles without memory access and 2+k cycles with k wait cycles. MemReady already high in EXEC means zero waits.
- PSR: on the terminal cycle, if SetCode=1, PSR <= ~{FlagNegative, FlagZero, FlagOverflow, FlagCarry}. Otherwise PSR is held; it never changes in FETCH or WAIT.
- Next CSAR (terminal cycle) is selected by COND. Branch tests use the PSR value before this cycle's update.
  - 0: CSAR+1
  - 1: n ? JADDR : CSAR+1
  - 2: z ? JADDR : CSAR+1
  - 3: v ? JADDR : CSAR+1
  - 4: c ? JADDR : CSAR+1
  - 5: IR[13] ? JADDR : CSAR+1
  - 6: JADDR
  - 7: decode = {1'b1, IR[31:30], IR[24:19], 2'b00}
- CSAR+1 wraps 2047 -> 0.
- RD and WR both set is illegal. The block behaves as a single access and waits for one MemReady.

Optional Feature:
- Macro UCONTROL_SINGLESTEP_EN adds input uCONTROL_Step_In (1 bit).
- When defined: FETCH is held, with MIR not loaded, until a rising edge of Step_In is sampled (Step registered internally). Exactly one microinstruction executes per step pulse.
- When undefined: the port is absent and FETCH always advances after one cycle.

Test Plan:
- Reset release:
  - Stimulus: ResetInLow 0->1, CSData at address 0 = {C=6'd5, CMUX=0, ALU=4'h3, COND=0}.
  - Required: CSAddress=0 in the first cycle; DirC=5 and ALU=3 in the second; CSAddress=1 in the third.
- Memory wait:
  - Stimulus: microword RD=1, C=6'd3; MemReady low for 3 cycles, then high.
  - Required: RD held 4 cycles; DirC=0 for 3 cycles, then 3 on the ready cycle; the next FETCH starts on the following cycle.
- Conditional branch on zero:
  - Stimulus: SetCode=1 with FlagZero=0 (active-low) at CSAR 10; next microword at CSAR 11 is COND=2, JADDR=11'h400.
  - Required: PSR=4'b0100; CSAddress=0x400. Repeat with FlagZero=1: CSAddress=12.
- Decode:
  - Stimulus: IR=32'h8200_4000 (op=10, op3=000000), COND=7.
  - Required: CSAddress=11'b1_10_000000_00 = 0x600.
- Async reset mid-wait:
  - Stimulus: WR=1 with MemReady=0; ResetInLow=0 asynchronously.
  - Required: WR=0 and CSAddress=CSAR_RESET without waiting for a clock edge; PSR=0.
- Wrap and single step:
  - Stimulus: COND=0 at CSAR 2047.
  - Required: CSAddress=0 next.
  - With UCONTROL_SINGLESTEP_EN: no CSAR advance until a Step pulse; exactly one advance per pulse.
